prg_seq: RTL and testbench
==========================

# prg_seq

Program sequencer for the 4-bit teaching CPU. It owns the program counter that addresses the 16-word program ROM and latches the returned machine code into an instruction register. It issues a one-cycle execute strobe to the datapath and resolves `JMP` and `JNC` branches. It runs either free-running at a slow, human-visible instruction rate or one instruction per push-button press.

## Interface
Parameters:
- `DIV_W` — default 24 — width of the run-mode divider counter.
- `TICK_DIV` — default 24'd10_000_000 — clock cycles per instruction in run mode. Legal range 3 .. 2^DIV_W−1.

Ports:
- `CLK` — in — 1 — system clock. Single clock domain.
- `N_RST` — in — 1 — reset, asynchronous, active-low.
- `RUN` — in — 1 — mode select, level. 1 = free-run; 0 = single-step.
- `STEP` — in — 1 — raw push-button level, asynchronous to `CLK`.
- `MC_CODE` — in — 8 — machine code from the program ROM, combinationally addressed by `PCNT`.
- `CARRY` — in — 1 — registered carry flag from the datapath.
- `PCNT` — out — 4 — program counter, drives the ROM address.
- `IR` — out — 8 — instruction register. `IR[7:4]` = opcode, `IR[3:0]` = operand.
- `EXEC_EN` — out — 1 — one-cycle strobe; the datapath executes `IR` in this cycle.
- `STATE` — out — 2 — current state, for the debug display.

## Operation
- States: `IDLE` = 2'b00, `FETCH` = 2'b01, `EXEC` = 2'b10. Encoding 2'b11 is unused; if entered, the next state is `IDLE`.
- Trigger:
  - `RUN` = 1: trigger = divider tick.
  - `RUN` = 0: trigger = rising edge of the synchronized `STEP`.
- `IDLE` → `FETCH` on trigger; otherwise stay in `IDLE`.
- `FETCH` → `EXEC`, unconditionally. `IR` ← `MC_CODE` at the end of the `FETCH` cycle.
- `EXEC` → `IDLE`, unconditionally. `EXEC_EN` = 1 only in `EXEC`. At the end of `EXEC`, `PCNT` updates:
  - `IR[7:4]` = 4'hD (`JMP`): `PCNT` ← `IR[3:0]`.
  - `IR[7:4]` = 4'hE (`JNC`) and `CARRY` = 0: `PCNT` ← `IR[3:0]`.
  - `JNC` with `CARRY` = 1, or any other opcode: `PCNT` ← `PCNT` + 1, mod 16 (4'hF wraps to 4'h0).
- `CARRY` is sampled in the `EXEC` cycle. It therefore reflects the flag left by the previous instruction.
- Divider:
  - `RUN` = 1: counts 0 .. `TICK_DIV`−1, then wraps. Tick = (count == `TICK_DIV`−1), one cycle wide.
  - `RUN` = 0: held at 0, no ticks.
  - The divider free-runs regardless of state.
- STEP path: two-flop synchronizer, then a third flop for edge detect. Edge = sync2 & ~sync3.
  - Step edges are ignored while `RUN` = 1.
- Triggers arriving in `FETCH` or `EXEC` are dropped, not queued.
- A self-loop (`JMP` to its own address) is the program's halt idiom. The sequencer keeps cycling; there is no special halt handling.
- `PCNT` changes only at the end of `EXEC` (and on reset).

## Timing
- Reset (`N_RST` = 0), asynchronous:
  - `PCNT` = 4'h0, `IR` = 8'h00, `EXEC_EN` = 0, `STATE` = `IDLE`, divider = 0.
  - All three `STEP` flops = 1, so a button held through reset release yields no step.
- Reset release takes effect at the next `CLK` edge. The first instruction executed is always at address 0.
- Reset asserted mid-`FETCH` or mid-`EXEC`: the in-flight instruction is abandoned and `EXEC_EN` drops immediately.
- Trigger seen in `IDLE` at cycle t:
  - `STATE` = `FETCH` in t+1.
  - `IR` valid and `EXEC_EN` = 1 in t+2.
  - New `PCNT` visible in t+3.
- Instruction period:
  - Run mode: exactly `TICK_DIV` cycles.
  - Step mode: 3 cycles minimum; button edge to `FETCH` = 3 cycles (2 sync + 1 edge detect).
- `RUN` toggled 1→0 mid-instruction: the current instruction completes; no further ticks.
- `RUN` toggled 0→1: the first tick comes `TICK_DIV` cycles later.
- `STEP` edge coinciding with `RUN` rising: ignored.

## Test plan
- Reset, `RUN` = 0, one `STEP` press, ROM[0] = 8'h90 → `EXEC_EN` pulses once, `IR` = 8'h90, `PCNT` 0→1; with no further press, `PCNT` stays at 1.
- `RUN` = 1, `TICK_DIV` = 5, ROM = 8'h90, 8'h4E, 8'hD0 → `PCNT` sequence 0,1,2,0,1…; `EXEC_EN` period 5 cycles; `IR` = 8'hD0 at `PCNT` 2.
- `JNC`: ROM[3] = 8'hE2; `CARRY` = 0 → `PCNT` 3→2; `CARRY` = 1 → `PCNT` 3→4.
- Wrap: ROM[F] = 8'h11 → `PCNT` F→0.
- `STEP` held through reset release → no `EXEC_EN`. Two presses 4 cycles apart with the button glitch-free → exactly two instructions. Press during `EXEC` in run mode → ignored.
- `N_RST` asserted in the `EXEC` cycle → `EXEC_EN` = 0, `PCNT` = 0, `IR` = 8'h00 asynchronously; after release, the next trigger fetches address 0.

Source files
------------

// File: rtl/prg_seq.sv
`default_nettype none
// ============================================================================
// Module   : prg_seq
// Purpose  : Program sequencer for the 4-bit teaching CPU. It runs a
//            fetch/execute cycle, resolves branches, and can run free or
//            step one instruction per button press.
// Revision : 1.0  initial release
// ============================================================================

module prg_seq #(
  parameter int               DIV_W    = 24,
  parameter logic [DIV_W-1:0] TICK_DIV = 24'd10_000_000
) (
  input  logic       CLK,
  input  logic       N_RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic [7:0] MC_CODE,
  input  logic       CARRY,
  output logic [3:0] PCNT,
  output logic [7:0] IR,
  output logic       EXEC_EN,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } state_e;

  localparam logic [3:0]       OP_JMP    = 4'hD;
  localparam logic [3:0]       OP_JNC    = 4'hE;
  localparam logic [DIV_W-1:0] TICK_LAST = TICK_DIV - DIV_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       step_q;
  logic             tick;
  logic             step_edge;
  logic             trigger;
  logic             take_branch;
  logic             exec_en;

  // Run-mode divider: held at zero while stepping, so the first tick after
  // RUN rises comes a full TICK_DIV cycles later.
  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (!RUN) begin
      div_d = '0;
    end else if (div_q == TICK_LAST) begin
      div_d = '0;
      tick  = 1'b1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Flops reset to 1 so a button held through reset release is not a press.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      step_q <= 3'b111;
    end else begin
      step_q <= {step_q[1:0], STEP};
    end
  end

  assign step_edge   = step_q[1] & ~step_q[2];
  assign trigger     = RUN ? tick : step_edge;
  assign take_branch = (ir_q[7:4] == OP_JMP) ||
                       ((ir_q[7:4] == OP_JNC) && !CARRY);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    exec_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = MC_CODE;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        state_d = S_IDLE;
        pc_d    = take_branch ? ir_q[3:0] : pc_q + 4'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= S_IDLE;
      pc_q    <= 4'h0;
      ir_q    <= 8'h00;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      div_q   <= div_d;
    end
  end

  // Strobe decoded straight from the state register so reset kills it at once.
  assign EXEC_EN = exec_en;
  assign PCNT    = pc_q;
  assign IR      = ir_q;
  assign STATE   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_prg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_prg_seq
// Purpose  : Directed self-checking bench for prg_seq with a small ROM model.
// Revision : 1.0  initial release
// ============================================================================

module tb_prg_seq;

  logic       CLK = 1'b0;
  logic       N_RST = 1'b0;
  logic       RUN = 1'b0;
  logic       STEP = 1'b0;
  logic       CARRY = 1'b0;
  logic [7:0] MC_CODE;
  logic [3:0] PCNT;
  logic [7:0] IR;
  logic       EXEC_EN;
  logic [1:0] STATE;

  logic [7:0] rom [16];
  int         n_cmp = 0;
  int         n_err = 0;
  int         exec_cnt = 0;
  int         base;

  prg_seq #(.DIV_W(24), .TICK_DIV(24'd5)) dut (
    .CLK     (CLK),
    .N_RST   (N_RST),
    .RUN     (RUN),
    .STEP    (STEP),
    .MC_CODE (MC_CODE),
    .CARRY   (CARRY),
    .PCNT    (PCNT),
    .IR      (IR),
    .EXEC_EN (EXEC_EN),
    .STATE   (STATE)
  );

  always #5 CLK = ~CLK;

  assign MC_CODE = rom[PCNT];

  always @(posedge CLK) begin
    if (EXEC_EN) exec_cnt <= exec_cnt + 1;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_exec(input string tag, input int limit);
    int k;
    k = 0;
    while (EXEC_EN !== 1'b1 && k < limit) begin
      cyc(1);
      k++;
    end
    chk(tag, {7'd0, EXEC_EN}, 8'h01);
  endtask

  task automatic do_step();
    STEP = 1'b1;
    cyc(2);
    STEP = 1'b0;
    cyc(6);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h90;
    rom[1]  = 8'h4E;
    rom[2]  = 8'hD0;
    rom[3]  = 8'hE2;
    rom[15] = 8'h11;

    // Reset state
    cyc(3);
    chk("rst_pcnt",  {4'h0, PCNT}, 8'h00);
    chk("rst_ir",    IR, 8'h00);
    chk("rst_exec",  {7'd0, EXEC_EN}, 8'h00);
    chk("rst_state", {6'd0, STATE}, 8'h00);
    N_RST = 1'b1;
    cyc(4);

    // Single step: edge-to-FETCH latency 3 cycles, then EXEC, then new PC
    STEP = 1'b1;
    cyc(2);
    chk("step_idle_wait", {6'd0, STATE}, 8'h00);
    cyc(1);
    chk("step_fetch", {6'd0, STATE}, 8'h01);
    cyc(1);
    chk("step_exec_en", {7'd0, EXEC_EN}, 8'h01);
    chk("step_ir", IR, 8'h90);
    chk("step_pc_hold", {4'h0, PCNT}, 8'h00);
    cyc(1);
    chk("step_pc_new", {4'h0, PCNT}, 8'h01);
    chk("step_state_idle", {6'd0, STATE}, 8'h00);
    base = exec_cnt;
    cyc(10);
    chk("step_no_repeat", 8'(exec_cnt - base), 8'h00);
    chk("step_pc_stays", {4'h0, PCNT}, 8'h01);
    STEP = 1'b0;

    // Run mode, TICK_DIV = 5
    N_RST = 1'b0;
    cyc(1);
    N_RST = 1'b1;
    cyc(2);
    RUN = 1'b1;
    cyc(5);
    chk("run_first_gap", {7'd0, EXEC_EN}, 8'h00);
    cyc(1);
    chk("run_exec0", {7'd0, EXEC_EN}, 8'h01);
    chk("run_pc0", {4'h0, PCNT}, 8'h00);
    chk("run_ir0", IR, 8'h90);
    STEP = 1'b1;  // press while running: must not disturb the cadence
    base = exec_cnt;
    cyc(4);
    chk("run_gap", 8'(exec_cnt - base), 8'h01);
    STEP = 1'b0;
    cyc(1);
    chk("run_exec1", {7'd0, EXEC_EN}, 8'h01);
    chk("run_pc1", {4'h0, PCNT}, 8'h01);
    chk("run_ir1", IR, 8'h4E);
    cyc(5);
    chk("run_exec2", {7'd0, EXEC_EN}, 8'h01);
    chk("run_pc2", {4'h0, PCNT}, 8'h02);
    chk("run_ir2", IR, 8'hD0);
    cyc(5);
    chk("run_exec3", {7'd0, EXEC_EN}, 8'h01);
    chk("run_pc3", {4'h0, PCNT}, 8'h00);
    RUN = 1'b0;
    base = exec_cnt;
    cyc(15);
    chk("run_stop_count", 8'(exec_cnt - base), 8'h01);
    chk("run_stop_pc", {4'h0, PCNT}, 8'h01);

    // Branches and wrap in step mode
    rom[0] = 8'hD3;
    rom[2] = 8'hD3;
    rom[4] = 8'hDF;
    N_RST = 1'b0;
    cyc(1);
    N_RST = 1'b1;
    cyc(4);
    do_step();
    chk("jmp_to3", {4'h0, PCNT}, 8'h03);
    CARRY = 1'b0;
    do_step();
    chk("jnc_c0", {4'h0, PCNT}, 8'h02);
    do_step();
    chk("jmp_back3", {4'h0, PCNT}, 8'h03);
    CARRY = 1'b1;
    do_step();
    chk("jnc_c1", {4'h0, PCNT}, 8'h04);
    do_step();
    chk("jmp_toF", {4'h0, PCNT}, 8'h0F);
    do_step();
    chk("wrap_F0", {4'h0, PCNT}, 8'h00);

    // Reset in the EXEC cycle
    do_step();
    chk("pre_rst_pc", {4'h0, PCNT}, 8'h03);
    STEP = 1'b1;
    cyc(2);
    STEP = 1'b0;
    wait_exec("rst_mid_wait", 10);
    chk("rst_mid_ir_before", IR, 8'hE2);
    N_RST = 1'b0;
    #1;
    chk("rst_mid_exec", {7'd0, EXEC_EN}, 8'h00);
    chk("rst_mid_pc", {4'h0, PCNT}, 8'h00);
    chk("rst_mid_ir", IR, 8'h00);
    cyc(2);
    N_RST = 1'b1;
    cyc(3);
    STEP = 1'b1;
    cyc(2);
    STEP = 1'b0;
    wait_exec("after_rst_wait", 10);
    chk("after_rst_ir", IR, 8'hD3);
    cyc(5);

    // Button held through reset release
    STEP = 1'b1;
    N_RST = 1'b0;
    cyc(2);
    N_RST = 1'b1;
    base = exec_cnt;
    cyc(10);
    chk("held_no_exec", 8'(exec_cnt - base), 8'h00);
    chk("held_pc", {4'h0, PCNT}, 8'h00);
    STEP = 1'b0;
    cyc(4);

    // Two presses four cycles apart
    base = exec_cnt;
    STEP = 1'b1;
    cyc(2);
    STEP = 1'b0;
    cyc(2);
    STEP = 1'b1;
    cyc(2);
    STEP = 1'b0;
    cyc(10);
    chk("two_press_cnt", 8'(exec_cnt - base), 8'h02);
    chk("two_press_pc", {4'h0, PCNT}, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
